// File: rtl/uart_rx_brk.sv
// 16x-oversampled UART receiver with line-break detection.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_brk #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned BRK_BITS  = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_16x_baud,
   input  logic                 serial_in,
   input  logic                 parity_odd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_err,
   output logic                 parity_err,
   output logic                 break_start,
   output logic                 break_det,
   output logic                 rx_busy
);

   localparam int unsigned BIT_W   = $clog2(DATA_BITS);
   localparam int unsigned LOW_MAX = 16 * BRK_BITS;
   localparam int unsigned LOW_W   = $clog2(LOW_MAX + 1);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_rx_brk: DATA_BITS must be 5..8");
   end
   if (BRK_BITS < DATA_BITS + 3) begin : g_bad_brk_bits
      $error("uart_rx_brk: BRK_BITS must be >= DATA_BITS+3");
   end

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, WAIT_IDLE} state_t;
`endif

   state_t               r_state, w_state_nxt;
   logic                 r_sync1, r_sync2;
   logic [3:0]           r_tick, w_tick_nxt;
   logic [BIT_W-1:0]     r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic [DATA_BITS-1:0] r_data, w_data_nxt;
   logic [LOW_W-1:0]     r_low, w_low_nxt;
   logic                 r_valid, w_valid_nxt;
   logic                 r_ferr, w_ferr_nxt;
   logic                 r_perr, w_perr_nxt;
   logic                 r_pbad, w_pbad_nxt;
   logic                 r_bstart, w_bstart_nxt;
   logic                 r_bdet, w_bdet_nxt;
   logic                 r_busy;
   logic                 w_line;

   assign w_line = r_sync2;

   // Next-state and registered-output values; everything advances only on a tick.
   always_comb begin
      w_state_nxt  = r_state;
      w_tick_nxt   = r_tick;
      w_bit_nxt    = r_bit;
      w_shift_nxt  = r_shift;
      w_data_nxt   = r_data;
      w_low_nxt    = r_low;
      w_pbad_nxt   = r_pbad;
      w_bdet_nxt   = r_bdet;
      w_valid_nxt  = 1'b0;
      w_ferr_nxt   = 1'b0;
      w_perr_nxt   = 1'b0;
      w_bstart_nxt = 1'b0;
      if (en_16x_baud) begin
         if (w_line)
            w_low_nxt = '0;
         else if (r_low != LOW_W'(LOW_MAX))
            w_low_nxt = r_low + 1'b1;
         w_tick_nxt = r_tick + 4'd1;
         if (!w_line && r_low == LOW_W'(LOW_MAX - 1) &&
             r_state != BREAK && r_state != IDLE) begin
            w_state_nxt  = BREAK;
            w_bstart_nxt = 1'b1;
            w_bdet_nxt   = 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  w_tick_nxt = '0;
                  if (!w_line) w_state_nxt = START;
               end
               START: begin
                  if (r_tick == 4'd7) begin
                     w_tick_nxt  = '0;
                     w_bit_nxt   = '0;
                     w_state_nxt = w_line ? IDLE : DATA;
                  end
               end
               DATA: begin
                  if (r_tick == 4'd15) begin
                     w_shift_nxt = {w_line, r_shift[DATA_BITS-1:1]};
                     w_bit_nxt   = r_bit + 1'b1;
                     if (r_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (r_tick == 4'd15) begin
                     w_pbad_nxt  = ((^r_shift) ^ w_line) != parity_odd;
                     w_state_nxt = STOP;
                  end
               end
`endif
               STOP: begin
                  if (r_tick == 4'd15) begin
                     if (w_line) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_perr_nxt  = r_pbad;
                        w_state_nxt = IDLE;
                     end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                     end
                  end
               end
               BREAK: begin
                  // The releasing high sample is the first of the 16 idle ticks.
                  if (w_line) begin
                     w_bdet_nxt  = 1'b0;
                     w_tick_nxt  = 4'd1;
                     w_state_nxt = WAIT_IDLE;
                  end
               end
               WAIT_IDLE: begin
                  if (!w_line)
                     w_tick_nxt = '0;
                  else if (r_tick == 4'd15)
                     w_state_nxt = IDLE;
               end
               default: w_state_nxt = IDLE;
            endcase
         end
      end
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_tick   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_data   <= '0;
         r_low    <= '0;
         r_pbad   <= 1'b0;
         r_valid  <= 1'b0;
         r_ferr   <= 1'b0;
         r_perr   <= 1'b0;
         r_bstart <= 1'b0;
         r_bdet   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_sync1  <= serial_in;
         r_sync2  <= r_sync1;
         r_state  <= w_state_nxt;
         r_tick   <= w_tick_nxt;
         r_bit    <= w_bit_nxt;
         r_shift  <= w_shift_nxt;
         r_data   <= w_data_nxt;
         r_low    <= w_low_nxt;
         r_pbad   <= w_pbad_nxt;
         r_valid  <= w_valid_nxt;
         r_ferr   <= w_ferr_nxt;
         r_perr   <= w_perr_nxt;
         r_bstart <= w_bstart_nxt;
         r_bdet   <= w_bdet_nxt;
         r_busy   <= (w_state_nxt != IDLE);
      end
   end

   assign rx_data     = r_data;
   assign rx_valid    = r_valid;
   assign framing_err = r_ferr;
   assign break_start = r_bstart;
   assign break_det   = r_bdet;
   assign rx_busy     = r_busy;

`ifdef UART_RX_PARITY_EN
   assign parity_err = r_perr;
`else
   logic w_unused;
   assign w_unused   = parity_odd ^ r_perr ^ r_pbad;
   assign parity_err = 1'b0;
`endif

endmodule
